irq_debounce_latch: RTL

- Per-channel interrupt front end for the MCU. Synchronises and debounces raw external request lines and latches rising edges into sticky pending flags.
- Feeds the combinational OR-gate tree that merges interrupt sources. Also provides a registered OR of enabled pending flags, so downstream gating sees a glitch-free level.
- Software clears the pending flags through a write-1-to-clear strobe.

---
 rtl/irq_debounce_latch.sv | 112 +++++++++++
 1 files changed

// File: rtl/irq_debounce_latch.sv
// irq_debounce_latch: per-channel interrupt front end.
// Syncs, debounces and latches request edges into sticky pending flags.
//
// Ports:
//   Clock        system clock, rising edge
//   Reset_n      asynchronous active-low reset
//   Irq_In       raw asynchronous request lines, active high
//   Irq_Enable   per-channel enable, masks Irq_Out only
//   Clear_Strobe one-cycle write-1-to-clear strobe
//   Clear_Mask   pending bits cleared while Clear_Strobe=1
//   Pending      sticky pending flags
//   Debounced    debounced level per channel
//   Irq_Out      registered OR of enabled pending flags
//
// Build option: define IRQ_BOTH_EDGES_EN to latch Pending on falling
// debounced transitions as well as rising ones.

module irq_debounce_latch #(
   parameter int unsigned NR_OF_INPUTS    = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic                    Clock,
   input  logic                    Reset_n,
   input  logic [NR_OF_INPUTS-1:0] Irq_In,
   input  logic [NR_OF_INPUTS-1:0] Irq_Enable,
   input  logic                    Clear_Strobe,
   input  logic [NR_OF_INPUTS-1:0] Clear_Mask,
   output logic [NR_OF_INPUTS-1:0] Pending,
   output logic [NR_OF_INPUTS-1:0] Debounced,
   output logic                    Irq_Out
);

   localparam int unsigned N  = NR_OF_INPUTS;
   localparam int unsigned CW =
      ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1
                                        : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [N-1:0]  sync1_q;
   logic [N-1:0]  sync2_q;
   logic [N-1:0]  deb_q;
   logic [N-1:0]  deb_d;
   logic [N-1:0]  pend_q;
   logic [N-1:0]  pend_d;
   logic [N-1:0]  upd;
   logic [N-1:0]  set_v;
   logic [N-1:0]  clr_v;
   logic [CW-1:0] cnt_q [N];
   logic [CW-1:0] cnt_d [N];
   logic          irq_q;
   logic          irq_d;

   // Debounce: the level only moves after DEBOUNCE_CYCLES consecutive
   // synchronised samples disagree with it; any agreement restarts.
   always_comb begin
      deb_d = deb_q;
      upd   = '0;
      for (int i = 0; i < int'(N); i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               deb_d[i] = sync2_q[i];
               upd[i]   = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
`ifdef IRQ_BOTH_EDGES_EN
      set_v = upd;
`else
      set_v = upd & deb_d;
`endif
      clr_v  = {N{Clear_Strobe}} & Clear_Mask;
      // Set is OR-ed in after the clear so a collision keeps the flag.
      pend_d = (pend_q & ~clr_v) | set_v;
      // A channel drives Irq_Out only once its flag is already
      // registered and survives this cycle: clears drop the output
      // at once, fresh captures reach it one edge after Pending.
      irq_d  = |(pend_q & pend_d & Irq_Enable);
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         deb_q   <= '0;
         pend_q  <= '0;
         irq_q   <= 1'b0;
         for (int i = 0; i < int'(N); i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q <= Irq_In;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         pend_q  <= pend_d;
         irq_q   <= irq_d;
         for (int i = 0; i < int'(N); i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign Pending   = pend_q;
   assign Debounced = deb_q;
   assign Irq_Out   = irq_q;

endmodule
